// File: rtl/beamforming_pkg.sv
// Shared definitions for the element-activation feedback checker:
// default array width, checker FSM encoding and step-index sizing.
package beamforming_pkg;

    // Default transducer array width (one feedback line per element).
    localparam int NUM_ELEMENTS_DEF = 8;

    // Checker FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2,
        ST_FAIL  = 2'd3
    } chk_state_t;

    // Width of the step index: it counts 0..num_elements, where the last
    // value is the all-zero gap step, so num_elements+1 codes are needed.
    function automatic int idx_width(input int num_elements);
        return (num_elements < 1) ? 1 : $clog2(num_elements + 1);
    endfunction

endpackage

// File: rtl/feedback_debounce.sv
// Input conditioning for the element-feedback bus: two-flop synchronizer,
// stability counter and a single-cycle accept pulse for each new settled value.
module feedback_debounce
    import beamforming_pkg::*;
#(
    parameter int WIDTH         = NUM_ELEMENTS_DEF,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_hist,   // forget the last accepted value
    input  logic [WIDTH-1:0] feedback,     // asynchronous pins
    output logic [WIDTH-1:0] feedback_s,   // synchronized bus
    output logic             accept,       // one-cycle pulse, value on accept_value
    output logic [WIDTH-1:0] accept_value
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);

    logic [WIDTH-1:0] sync1;
    logic [CW-1:0]    stable_cnt;
    logic [WIDTH-1:0] last_value;
    logic             hist_valid;

    // Synchronizer plus run-length counter of the synchronized value.
    // The counter restarts at 1 on the edge feedback_s takes a new value,
    // so it equals the number of cycles feedback_s has held its value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= '0;
            feedback_s <= '0;
            stable_cnt <= '0;
        end else begin
            sync1      <= feedback;
            feedback_s <= sync1;
            if (sync1 != feedback_s)
                stable_cnt <= CW'(1);
            else if (stable_cnt != SETTLE_MAX)
                stable_cnt <= stable_cnt + CW'(1);
        end
    end

    // Acceptance history: remembering the last accepted value is what
    // turns the saturated counter into a single-cycle accept pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_value <= '0;
            hist_valid <= 1'b0;
        end else if (clear_hist) begin
            last_value <= '0;
            hist_valid <= 1'b0;
        end else if (accept) begin
            last_value <= feedback_s;
            hist_valid <= 1'b1;
        end
    end

    assign accept       = (stable_cnt == SETTLE_MAX) &&
                          (!hist_valid || (feedback_s != last_value));
    assign accept_value = feedback_s;

endmodule

// File: rtl/element_feedback_checker.sv
// Receive-side checker for the sequential element-activation test. Tracks
// the walking one-hot sweep (bit 0 first, then an all-zero gap) on the
// element-feedback bus, counts clean sweeps and latches the first deviation.
module element_feedback_checker
    import beamforming_pkg::*;
#(
    parameter int NUM_ELEMENTS   = NUM_ELEMENTS_DEF,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int PASS_SWEEPS    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_ELEMENTS-1:0] feedback,
    output logic                    led_pass,
    output logic                    led_fail,
    output logic                    busy,
    output logic [7:0]              sweep_count,
    output logic [3:0]              fail_index,
    output logic [NUM_ELEMENTS-1:0] fail_value
);

    localparam int IW = idx_width(NUM_ELEMENTS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] GAP_IDX   = IW'(NUM_ELEMENTS);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    PASS_CNT  = 8'(PASS_SWEEPS);
    localparam logic [NUM_ELEMENTS-1:0] ONE = NUM_ELEMENTS'(1);

    chk_state_t              state;
    logic [IW-1:0]           idx;
    logic [TW-1:0]           timer;
    logic [NUM_ELEMENTS-1:0] feedback_s;
    logic                    accept;
    logic [NUM_ELEMENTS-1:0] accept_value;
    logic [NUM_ELEMENTS-1:0] expected;
    logic                    match;

    feedback_debounce #(
        .WIDTH         (NUM_ELEMENTS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_debounce (
        .clock        (clock),
        .reset        (reset),
        .clear_hist   (!enable),
        .feedback     (feedback),
        .feedback_s   (feedback_s),
        .accept       (accept),
        .accept_value (accept_value)
    );

    // Expected bus value for the current step: one-hot bit idx, or the gap.
    always_comb begin
        expected = '0;
        if (idx != GAP_IDX)
            expected = ONE << idx;
        match = (accept_value == expected);
    end

    // Checker FSM with timeout counter and registered result outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            timer       <= '0;
            led_pass    <= 1'b0;
            led_fail    <= 1'b0;
            busy        <= 1'b0;
            sweep_count <= '0;
            fail_index  <= '0;
            fail_value  <= '0;
        end else if (!enable) begin
            state       <= ST_IDLE;
            idx         <= '0;
            timer       <= '0;
            led_pass    <= 1'b0;
            led_fail    <= 1'b0;
            busy        <= 1'b0;
            sweep_count <= '0;
            fail_index  <= '0;
            fail_value  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_SYNC;
                    busy  <= 1'b1;
                end

                // Wait for a gap so tracking always starts at a sweep boundary.
                ST_SYNC: begin
                    if (accept && (accept_value == '0)) begin
                        state <= ST_TRACK;
                        idx   <= '0;
                        timer <= '0;
                    end
                end

                // An accept in the same cycle as the timer expiring wins.
                ST_TRACK: begin
                    if (accept) begin
                        timer <= '0;
                        if (match) begin
                            if (idx == GAP_IDX) begin
                                idx <= '0;
                                if (sweep_count != 8'hFF) begin
                                    sweep_count <= sweep_count + 8'd1;
                                    if ((sweep_count + 8'd1) == PASS_CNT)
                                        led_pass <= 1'b1;
                                end
                            end else begin
                                idx <= idx + IW'(1);
                            end
                        end else begin
                            state      <= ST_FAIL;
                            busy       <= 1'b0;
                            led_fail   <= 1'b1;
                            led_pass   <= 1'b0;
                            fail_index <= 4'(idx);
                            fail_value <= accept_value;
                        end
                    end else if (timer == TIMER_END) begin
                        state      <= ST_FAIL;
                        busy       <= 1'b0;
                        led_fail   <= 1'b1;
                        led_pass   <= 1'b0;
                        fail_index <= 4'(idx);
                        fail_value <= feedback_s;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                // Sticky until enable drops or reset.
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_element_feedback_checker.sv
// Directed bench for element_feedback_checker: table of held feedback values
// with expected outputs, plus hand sequences for enable drop, mid-sweep reset
// and stall timeout.
module tb_element_feedback_checker;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] feedback;
    logic       led_pass;
    logic       led_fail;
    logic       busy;
    logic [7:0] sweep_count;
    logic [3:0] fail_index;
    logic [7:0] fail_value;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] fb;
        int         hold;
        logic [7:0] cnt;
        logic       pass;
        logic       fail;
        logic       bsy;
        logic [3:0] fidx;
        logic [7:0] fval;
    } vec_t;

    vec_t tbl[$];

    element_feedback_checker #(
        .NUM_ELEMENTS   (8),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100),
        .PASS_SWEEPS    (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .feedback    (feedback),
        .led_pass    (led_pass),
        .led_fail    (led_fail),
        .busy        (busy),
        .sweep_count (sweep_count),
        .fail_index  (fail_index),
        .fail_value  (fail_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] got %0h expected %0h", name, tag, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] fb, input int hold, input logic [7:0] cnt,
                       input logic pass, input logic fail, input logic bsy,
                       input logic [3:0] fidx, input logic [7:0] fval);
        vec_t v;
        v.fb = fb; v.hold = hold; v.cnt = cnt; v.pass = pass; v.fail = fail;
        v.bsy = bsy; v.fidx = fidx; v.fval = fval;
        tbl.push_back(v);
    endtask

    // Adds the eight one-hot steps, all with the same expected outputs.
    task automatic add_ones(input logic [7:0] cnt, input logic pass);
        for (int i = 0; i < 8; i++) add(8'(1 << i), 20, cnt, pass, 1'b0, 1'b1, 4'd0, 8'd0);
    endtask

    task automatic run_table(input int base);
        for (int i = 0; i < tbl.size(); i++) begin
            feedback = tbl[i].fb;
            repeat (tbl[i].hold) @(negedge clock);
            chk("sweep_count", base + i, 32'(sweep_count), 32'(tbl[i].cnt));
            chk("led_pass",    base + i, 32'(led_pass),    32'(tbl[i].pass));
            chk("led_fail",    base + i, 32'(led_fail),    32'(tbl[i].fail));
            chk("busy",        base + i, 32'(busy),        32'(tbl[i].bsy));
            chk("fail_index",  base + i, 32'(fail_index),  32'(tbl[i].fidx));
            chk("fail_value",  base + i, 32'(fail_value),  32'(tbl[i].fval));
        end
        tbl.delete();
    endtask

    task automatic chk_cleared(input string name);
        chk({name, " led_pass"},    0, 32'(led_pass),    0);
        chk({name, " led_fail"},    0, 32'(led_fail),    0);
        chk({name, " busy"},        0, 32'(busy),        0);
        chk({name, " sweep_count"}, 0, 32'(sweep_count), 0);
        chk({name, " fail_index"},  0, 32'(fail_index),  0);
        chk({name, " fail_value"},  0, 32'(fail_value),  0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        feedback = 8'h00;
        repeat (3) @(negedge clock);
        chk_cleared("reset");
        reset  = 1'b0;
        enable = 1'b1;

        // Two clean sweeps, then a skipped step (0x04 missing).
        add(8'h00, 20, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        add_ones(8'd0, 1'b0);
        add(8'h00, 20, 8'd1, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        add_ones(8'd1, 1'b0);
        add(8'h00, 20, 8'd2, 1'b1, 1'b0, 1'b1, 4'd0, 8'h00);
        add(8'h01, 20, 8'd2, 1'b1, 1'b0, 1'b1, 4'd0, 8'h00);
        add(8'h02, 20, 8'd2, 1'b1, 1'b0, 1'b1, 4'd0, 8'h00);
        add(8'h08, 20, 8'd2, 1'b0, 1'b1, 1'b0, 4'd2, 8'h08);
        add(8'h04, 20, 8'd2, 1'b0, 1'b1, 1'b0, 4'd2, 8'h08);
        run_table(0);

        // One-cycle enable drop clears everything, then SYNC.
        enable = 1'b0;
        @(negedge clock);
        chk_cleared("enable_drop");
        enable = 1'b1;
        @(negedge clock);
        chk("enable_raise busy", 0, 32'(busy), 1);

        // Clean sweep with a 2-cycle 0x10 glitch inside the 0x02 step.
        add(8'h00, 20, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        add(8'h01, 20, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        add(8'h02,  8, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        add(8'h10,  2, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        add(8'h02, 10, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        for (int i = 2; i < 8; i++) add(8'(1 << i), 20, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        add(8'h00, 20, 8'd1, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        add_ones(8'd1, 1'b0);
        add(8'h00, 20, 8'd2, 1'b1, 1'b0, 1'b1, 4'd0, 8'h00);
        // Advance to idx=5 (0x01..0x10 accepted).
        for (int i = 0; i < 5; i++) add(8'(1 << i), 20, 8'd2, 1'b1, 1'b0, 1'b1, 4'd0, 8'h00);
        run_table(100);

        // Mid-sweep reset, resume at 0x40: needs a fresh gap before tracking.
        reset    = 1'b1;
        feedback = 8'h40;
        repeat (2) @(negedge clock);
        chk_cleared("mid_reset");
        reset = 1'b0;
        add(8'h40, 20, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        add(8'h80, 20, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        add(8'h00, 20, 8'd0, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        add_ones(8'd0, 1'b0);
        add(8'h00, 20, 8'd1, 1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        run_table(200);

        // Stall: 0x01 accepted on the 6th edge after driving; timeout 100 later.
        feedback = 8'h01;
        repeat (105) @(negedge clock);
        chk("timeout early led_fail", 0, 32'(led_fail), 0);
        chk("timeout early busy",     0, 32'(busy),     1);
        @(negedge clock);
        chk("timeout led_fail",    0, 32'(led_fail),    1);
        chk("timeout fail_index",  0, 32'(fail_index),  1);
        chk("timeout fail_value",  0, 32'(fail_value),  8'h01);
        chk("timeout busy",        0, 32'(busy),        0);
        chk("timeout sweep_count", 0, 32'(sweep_count), 1);

        // Feedback after a fail is ignored.
        add(8'h02, 20, 8'd1, 1'b0, 1'b1, 1'b0, 4'd1, 8'h01);
        run_table(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
